// File: rtl/dma_desc_sequencer_pkg.sv
// dma_pkg: shared definitions for the DMA descriptor sequencer.
//   - register word indices of the PS-facing register file
//   - sequencer state encoding
//   - packed queue entry layout (one MM2S + S2MM transfer pair)
package dma_pkg;

  // The queue entry layout is fixed here. The top-level width parameters
  // select how many of these bits reach the ports, so they must not exceed
  // these widths.
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 32;
  localparam int USER_W = 65;

  localparam int REG_CTRL      = 0;
  localparam int REG_STATUS    = 1;
  localparam int REG_MM2S_ADDR = 2;
  localparam int REG_MM2S_LEN  = 3;
  localparam int REG_MM2S_USER = 4;
  localparam int REG_S2MM_ADDR = 5;
  localparam int REG_S2MM_LEN  = 6;
  localparam int REG_PUSH      = 7;
  localparam int REG_DONE_CNT  = 8;
  localparam int REG_IRQ       = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] mm2s_addr;
    logic [LEN_W-1:0]  mm2s_len;
    logic [USER_W-1:0] mm2s_user;
    logic [ADDR_W-1:0] s2mm_addr;
    logic [LEN_W-1:0]  s2mm_len;
  } entry_t;

endpackage

// File: rtl/dma_desc_fifo.sv
// dma_desc_fifo: synchronous FIFO holding queued descriptor pairs.
//   clk, rstn      : clock, asynchronous active-low reset
//   flush          : empties the queue (wins over push/pop)
//   push, din      : enqueue; ignored when full
//   pop            : dequeue head; ignored when empty
//   head, head_idx : current head entry and the slot it lives in
//   count, full, empty : occupancy
module dma_desc_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [IDX_W-1:0] head_idx,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign head     = mem[rd_ptr];
  assign head_idx = rd_ptr;

  // Storage carries no reset; only occupancy and pointers are control.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + IDX_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + IDX_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dma_desc_sequencer.sv
// dma_desc_sequencer: register-programmed queue of MM2S/S2MM descriptor
// pairs, issued back-to-back to the AXI DMA descriptor ports.
//   clk, rstn                 : clock, asynchronous active-low reset
//   reg_wr_*/reg_rd_*         : PS register access (word index), read data
//                               returned one cycle after reg_rd_en
//   mm2s_desc/user/valid/ready: MM2S descriptor port ({len, addr})
//   mm2s_status_*             : MM2S completion status
//   s2mm_desc/tag/valid/ready : S2MM descriptor port, tag = queue slot
//   s2mm_status_*             : S2MM completion status
//   irq                       : level interrupt (done | err) & irq_en
module dma_desc_sequencer
  import dma_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_LEN_WIDTH   = 32,
  parameter int AXI_TAG_WIDTH   = 8,
  parameter int AXIS_USER_WIDTH = 65,
  parameter int DEPTH           = 8,
  parameter int MAX_OUT         = 4
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  reg_wr_en,
  input  logic                                  reg_rd_en,
  input  logic [AXI_ADDR_WIDTH-1:0]             reg_wr_addr,
  input  logic [AXI_ADDR_WIDTH-1:0]             reg_rd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]             reg_wr_data,
  output logic [AXI_DATA_WIDTH-1:0]             reg_rd_data,
  output logic [AXI_ADDR_WIDTH+AXI_LEN_WIDTH-1:0] mm2s_desc,
  output logic [AXIS_USER_WIDTH-1:0]            mm2s_user,
  output logic                                  mm2s_valid,
  input  logic                                  mm2s_ready,
  input  logic [3:0]                            mm2s_status_error,
  input  logic                                  mm2s_status_valid,
  output logic [AXI_ADDR_WIDTH+AXI_LEN_WIDTH-1:0] s2mm_desc,
  output logic [AXI_TAG_WIDTH-1:0]              s2mm_tag,
  output logic                                  s2mm_valid,
  input  logic                                  s2mm_ready,
  input  logic [3:0]                            s2mm_status_error,
  input  logic                                  s2mm_status_valid,
  output logic                                  irq
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam int         CNT_W     = IDX_W + 1;
  localparam logic [7:0] MAX_OUT_C = 8'(MAX_OUT);

  function automatic logic is_reg(input logic [AXI_ADDR_WIDTH-1:0] addr, input int idx);
    return addr == AXI_ADDR_WIDTH'(idx);
  endfunction

  state_t           state;
  state_t           state_nx;
  entry_t           stage;
  entry_t           head;
  logic [IDX_W-1:0] head_idx;
  logic [CNT_W-1:0] q_count;
  logic             q_full;
  logic             q_empty;

  logic             irq_en;
  logic             overflow;
  logic             error_flag;
  logic [7:0]       err_code;
  logic [7:0]       err_pend;
  logic [31:0]      done_count;
  logic [1:0]       irq_bits;
  logic [7:0]       mm2s_out;
  logic [7:0]       s2mm_out;
  logic             mm2s_acc;
  logic             s2mm_acc;

  logic             wr_ctrl;
  logic             start;
  logic             clear;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             mm2s_hs;
  logic             s2mm_hs;
  logic             mm2s_dec;
  logic             s2mm_dec;
  logic             err_hit;
  logic             enter_halt;
  logic             set_done;
  logic             set_err;
  logic [31:0]      rd_mux;

  // Register write decode; start and clear are single-cycle strobes.
  assign wr_ctrl  = reg_wr_en && is_reg(reg_wr_addr, REG_CTRL);
  assign start    = wr_ctrl && reg_wr_data[0];
  assign clear    = wr_ctrl && reg_wr_data[1] && (state == ST_IDLE);
  assign push_req = reg_wr_en && is_reg(reg_wr_addr, REG_PUSH);
  assign push_ok  = push_req && !q_full;

  dma_desc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (clear),
    .push     (push_ok),
    .din      (stage),
    .pop      (pop),
    .head     (head),
    .head_idx (head_idx),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  // A channel offers the head only until it has taken it, and only while
  // it has room for another in-flight descriptor.
  assign mm2s_valid = (state == ST_ISSUE) && !q_empty && !mm2s_acc && (mm2s_out != MAX_OUT_C);
  assign s2mm_valid = (state == ST_ISSUE) && !q_empty && !s2mm_acc && (s2mm_out != MAX_OUT_C);

  // Payloads are forced to zero while not offered so idle ports read clean.
  assign mm2s_desc = mm2s_valid ? {AXI_LEN_WIDTH'(head.mm2s_len), AXI_ADDR_WIDTH'(head.mm2s_addr)} : '0;
  assign mm2s_user = mm2s_valid ? AXIS_USER_WIDTH'(head.mm2s_user) : '0;
  assign s2mm_desc = s2mm_valid ? {AXI_LEN_WIDTH'(head.s2mm_len), AXI_ADDR_WIDTH'(head.s2mm_addr)} : '0;
  assign s2mm_tag  = s2mm_valid ? AXI_TAG_WIDTH'(head_idx) : '0;

  assign mm2s_hs  = mm2s_valid && mm2s_ready;
  assign s2mm_hs  = s2mm_valid && s2mm_ready;
  // A status with nothing outstanding is stray and ignored entirely.
  assign mm2s_dec = mm2s_status_valid && (mm2s_out != '0);
  assign s2mm_dec = s2mm_status_valid && (s2mm_out != '0);
  assign err_hit  = (mm2s_dec && (mm2s_status_error != 4'h0)) ||
                    (s2mm_dec && (s2mm_status_error != 4'h0));

  assign irq = (|irq_bits) && irq_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    pop        = 1'b0;
    enter_halt = 1'b0;
    set_done   = 1'b0;
    set_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !q_empty) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (err_hit) begin
          state_nx   = ST_HALT;
          enter_halt = 1'b1;
        end else if ((mm2s_acc || mm2s_hs) && (s2mm_acc || s2mm_hs)) begin
          pop = 1'b1;
          // A same-cycle push keeps the queue non-empty.
          if ((q_count == CNT_W'(1)) && !push_ok) state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (err_hit) begin
          state_nx   = ST_HALT;
          enter_halt = 1'b1;
        end else if (!q_empty) begin
          state_nx = ST_ISSUE;
        end else if ((mm2s_out == '0) && (s2mm_out == '0)) begin
          state_nx = ST_IDLE;
          set_done = 1'b1;
        end
      end
      ST_HALT: begin
        if ((mm2s_out == '0) && (s2mm_out == '0)) begin
          state_nx = ST_IDLE;
          set_err  = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Accepted flags live only for the current head in ISSUE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mm2s_acc <= 1'b0;
      s2mm_acc <= 1'b0;
    end else if ((state != ST_ISSUE) || pop) begin
      mm2s_acc <= 1'b0;
      s2mm_acc <= 1'b0;
    end else begin
      if (mm2s_hs) mm2s_acc <= 1'b1;
      if (s2mm_hs) s2mm_acc <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mm2s_out <= '0;
      s2mm_out <= '0;
    end else begin
      case ({mm2s_hs, mm2s_dec})
        2'b10:   mm2s_out <= mm2s_out + 8'd1;
        2'b01:   mm2s_out <= mm2s_out - 8'd1;
        default: mm2s_out <= mm2s_out;
      endcase
      case ({s2mm_hs, s2mm_dec})
        2'b10:   s2mm_out <= s2mm_out + 8'd1;
        2'b01:   s2mm_out <= s2mm_out - 8'd1;
        default: s2mm_out <= s2mm_out;
      endcase
    end
  end

  // Error code is captured when the first error arrives and published
  // when the halt completes, unless an earlier error is still on record.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_pend   <= '0;
      err_code   <= '0;
      error_flag <= 1'b0;
      overflow   <= 1'b0;
      done_count <= '0;
    end else if (clear) begin
      err_pend   <= '0;
      err_code   <= '0;
      error_flag <= 1'b0;
      overflow   <= 1'b0;
      done_count <= '0;
    end else begin
      if (enter_halt)
        err_pend <= {(s2mm_dec ? s2mm_status_error : 4'h0),
                     (mm2s_dec ? mm2s_status_error : 4'h0)};
      if (set_err) begin
        error_flag <= 1'b1;
        if (!error_flag) err_code <= err_pend;
      end
      if (push_req && q_full) overflow <= 1'b1;
      if (s2mm_dec && (s2mm_status_error == 4'h0)) done_count <= done_count + 32'd1;
    end
  end

  // IRQ bits are write-1-to-clear; a hardware set in the same cycle wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_bits <= '0;
    end else if (reg_wr_en && is_reg(reg_wr_addr, REG_IRQ)) begin
      irq_bits <= (irq_bits & ~reg_wr_data[1:0]) | {set_err, set_done};
    end else begin
      irq_bits <= irq_bits | {set_err, set_done};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_en <= 1'b0;
      stage  <= '0;
    end else if (reg_wr_en) begin
      if (is_reg(reg_wr_addr, REG_CTRL))      irq_en          <= reg_wr_data[2];
      if (is_reg(reg_wr_addr, REG_MM2S_ADDR)) stage.mm2s_addr <= ADDR_W'(reg_wr_data);
      if (is_reg(reg_wr_addr, REG_MM2S_LEN))  stage.mm2s_len  <= LEN_W'(reg_wr_data);
      if (is_reg(reg_wr_addr, REG_MM2S_USER)) stage.mm2s_user <= USER_W'(reg_wr_data);
      if (is_reg(reg_wr_addr, REG_S2MM_ADDR)) stage.s2mm_addr <= ADDR_W'(reg_wr_data);
      if (is_reg(reg_wr_addr, REG_S2MM_LEN))  stage.s2mm_len  <= LEN_W'(reg_wr_data);
    end
  end

  always_comb begin
    rd_mux = '0;
    if (is_reg(reg_rd_addr, REG_CTRL))      rd_mux = {29'b0, irq_en, 2'b0};
    if (is_reg(reg_rd_addr, REG_STATUS))    rd_mux = {8'h00, err_code, 8'(q_count), 3'b000,
                                                      overflow, error_flag, q_empty, q_full,
                                                      (state != ST_IDLE)};
    if (is_reg(reg_rd_addr, REG_MM2S_ADDR)) rd_mux = 32'(stage.mm2s_addr);
    if (is_reg(reg_rd_addr, REG_MM2S_LEN))  rd_mux = 32'(stage.mm2s_len);
    if (is_reg(reg_rd_addr, REG_MM2S_USER)) rd_mux = 32'(stage.mm2s_user);
    if (is_reg(reg_rd_addr, REG_S2MM_ADDR)) rd_mux = 32'(stage.s2mm_addr);
    if (is_reg(reg_rd_addr, REG_S2MM_LEN))  rd_mux = 32'(stage.s2mm_len);
    if (is_reg(reg_rd_addr, REG_DONE_CNT))  rd_mux = done_count;
    if (is_reg(reg_rd_addr, REG_IRQ))       rd_mux = {30'b0, irq_bits};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          reg_rd_data <= '0;
    else if (reg_rd_en) reg_rd_data <= AXI_DATA_WIDTH'(rd_mux);
  end

endmodule

// File: doc/dma_desc_sequencer.md
# dma_desc_sequencer

Register-programmed descriptor queue that sequences back-to-back loopback transfers through the MM2S and S2MM descriptor ports of the AXI DMA pair. The PS stages transfer pairs into a DEPTH-entry queue, then pulses start. The block issues the pairs, bounds in-flight transfers, counts completions, halts on any status error and raises a level interrupt. It replaces single-shot start/done polling in the PS with batched operation.

## Interface
- AXI_ADDR_WIDTH, 32, descriptor address width
- AXI_DATA_WIDTH, 32, register data width
- AXI_LEN_WIDTH, 32, byte-count width
- AXI_TAG_WIDTH, 8, S2MM tag width
- AXIS_USER_WIDTH, 65, MM2S tuser width
- DEPTH, 8, queue entries, power of 2, ≥2
- MAX_OUT, 4, max in-flight descriptors per channel, 1..255
- clk  in  1  single clock
- rstn  in  1  reset, asynchronous, active-low
- reg_wr_en, reg_rd_en  in  1  PS register strobes
- reg_wr_addr, reg_rd_addr  in  AXI_ADDR_WIDTH  word index
- reg_wr_data  in  AXI_DATA_WIDTH; reg_rd_data  out  AXI_DATA_WIDTH
- mm2s_desc  out  ADDR+LEN  {len, addr}; mm2s_user  out  AXIS_USER_WIDTH; mm2s_valid  out  1; mm2s_ready  in  1
- mm2s_status_error  in  4; mm2s_status_valid  in  1
- s2mm_desc  out  ADDR+LEN  {len, addr}; s2mm_tag  out  AXI_TAG_WIDTH; s2mm_valid  out  1; s2mm_ready  in  1
- s2mm_status_error  in  4; s2mm_status_valid  in  1
- irq  out  1  level interrupt

## Operation
- Registers:
  - 0 CTRL: b0 start (self-clearing), b1 clear (acts only in IDLE: flush queue, zero DONE_COUNT and sticky bits), b2 irq_en.
  - 1 STATUS, RO: b0 busy, b1 full, b2 empty, b3 error, b4 overflow, [15:8] entry count, [31:16] {s2mm_err, mm2s_err} of first error.
  - 2/3/4: MM2S addr/bytes/tuser staging.
  - 5/6: S2MM addr/bytes staging.
  - 7 PUSH: a write of any value enqueues the staged set. When full, the write is dropped and overflow is set.
  - 8 DONE_COUNT, RO: error-free S2MM completions, wraps at 2^32.
  - 9 IRQ: b0 done, b1 err; write-1-to-clear.
- irq = |(IRQ[1:0]) & irq_en.
- FSM states IDLE, ISSUE, DRAIN, HALT.
  - IDLE → ISSUE on start with queue non-empty. Start with queue empty is a no-op.
  - ISSUE presents the head entry on both channels. Each valid drops after its own handshake, tracked by per-channel accepted flags. The entry pops when both channels have accepted; the channels may accept in different cycles.
  - In ISSUE, a channel's valid is held low while that channel's outstanding count equals MAX_OUT.
  - ISSUE → DRAIN after a pop that leaves the queue empty.
  - DRAIN → IDLE when both outstanding counts are 0; sets IRQ.done.
  - Any status_valid with nonzero error in ISSUE or DRAIN → HALT. HALT drops both valids at once and does not pop a partially accepted head.
  - HALT → IDLE when both outstanding counts are 0; sets IRQ.err and error, and latches the first error code.
- Outstanding counters are per channel: +1 on accept, −1 on status_valid, unchanged when both happen in the same cycle. status_valid with count 0 is ignored.
- s2mm_tag = queue slot index, zero-extended.
- PUSH is legal in every state, so the queue can be refilled during ISSUE or DRAIN. Refill during DRAIN returns to ISSUE.

## Timing
- Reset: all outputs 0, state IDLE, queue empty, counters, staging and registers 0.
- reg_rd_data: 1-cycle latency, holds its value when reg_rd_en is low.
- A start written in cycle N gives ISSUE in N+1; valids are high in N+1, combinational from state, head and flags.
- desc, user and tag are stable while valid is high.
- A PUSH in cycle N is visible as non-empty at N+1.
- PUSH and pop in the same cycle: count is unchanged.
- A PS write to IRQ in the same cycle as a hardware set: the set wins.
- Reset mid-transfer abandons the queue and all in-flight accounting.

## Structure
- Package dma_pkg holds:
  - register index localparams;
  - the state enum;
  - a packed entry struct {mm2s_addr, mm2s_len, mm2s_user, s2mm_addr, s2mm_len}.
- Sub-module dma_desc_fifo: synchronous FIFO (DEPTH, WIDTH) with push, pop, head, count, full and empty outputs, and a flush input.

## Test plan
- Push 3 entries (MM2S 0x1000/64, S2MM 0x2000/64, …) with ready always high, then start → 3 handshakes per channel, tags 0,1,2, DONE_COUNT=3, IRQ.done set, irq=1 with irq_en.
- MAX_OUT=2 with status withheld, 4 entries → exactly 2 accepts per channel; releasing one status allows the 3rd accept.
- mm2s_ready low for 5 cycles while s2mm_ready is high → S2MM accepts first, MM2S 5 cycles later, then one pop.
- mm2s_status_error=4'h2 on the 2nd completion → HALT, no further valids, STATUS[19:16]=2 after drain, IRQ.err=1, entries remain queued.
- 9 pushes with DEPTH=8 → overflow=1, count=8. Clear in IDLE → empty, overflow=0, DONE_COUNT=0.
- Assert rstn low while in ISSUE → all outputs 0 asynchronously, STATUS empty after release.
